// File: rtl/fp8_add_arbiter.sv
// fp8_add_arbiter: shares one external pipelined FP8 adder among N requesters.
// A round-robin arbiter issues at most one operand pair per cycle into the
// adder. A tag pipeline of the same depth as the adder carries the owner's
// index alongside each operation, so every result returns to its requester.
// This block never looks inside the FP8 values; all arithmetic is in the adder.
module fp8_add_arbiter #(
    parameter int N       = 4,
    parameter int ADD_LAT = 4,
    parameter int IDW     = 2
) (
    input  logic             CLK,
    input  logic             RESETN,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_a,
    input  logic [8*N-1:0]   req_b,
    output logic [N-1:0]     req_ready,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    input  logic [7:0]       add_c,
    output logic [N-1:0]     rsp_valid,
    output logic [7:0]       rsp_data,
    output logic [IDW+1:0]   inflight_cnt
);

    localparam int CW = IDW + 2;

    logic [IDW-1:0] r_rr_ptr;
    logic [ADD_LAT-1:0] r_tag_vld;
    logic [IDW-1:0] r_tag_idx [ADD_LAT];
    logic [CW-1:0] r_inflight;

    logic           w_found;
    logic [IDW-1:0] w_winner;
    logic           w_transfer;
    logic           w_rsp;

    // Round-robin search: start one past the last winner, wrap, first set bit wins.
    // NOTE: blocking assignments in always_comb so w_found set in one loop
    // iteration is seen by the next; defaults at the top prevent latches.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int k = 1; k <= N; k++) begin
            if (!w_found && req_valid[(int'(r_rr_ptr) + k) % N]) begin
                w_found  = 1'b1;
                w_winner = IDW'((int'(r_rr_ptr) + k) % N);
            end
        end
    end

    // Grants are suppressed while reset is asserted so nothing is accepted
    // that the (also reset) tag pipe could not track.
    assign w_transfer = w_found & RESETN;
    assign w_rsp      = r_tag_vld[ADD_LAT-1];

    // One-hot grant and operand mux toward the adder; zeros when idle.
    always_comb begin
        req_ready = '0;
        add_a     = 8'h00;
        add_b     = 8'h00;
        if (w_transfer) begin
            req_ready[w_winner] = 1'b1;
            add_a               = req_a[8*w_winner +: 8];
            add_b               = req_b[8*w_winner +: 8];
        end
    end

    // Round-robin pointer advances to the winner only when a pair is accepted.
    // NOTE: non-blocking assignments for all sequential state, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_rr_ptr <= IDW'(N - 1);
        end else if (w_transfer) begin
            r_rr_ptr <= w_winner;
        end
    end

    // Tag pipe: {valid, owner} shifted in lockstep with the adder stages.
    // NOTE: the index array is reset along with the valids; it is only a few
    // flops and keeps the response decode free of X after reset.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_tag_vld <= '0;
            for (int k = 0; k < ADD_LAT; k++) begin
                r_tag_idx[k] <= '0;
            end
        end else begin
            r_tag_vld    <= {r_tag_vld[ADD_LAT-2:0], w_transfer};
            r_tag_idx[0] <= w_winner;
            for (int k = 1; k < ADD_LAT; k++) begin
                r_tag_idx[k] <= r_tag_idx[k-1];
            end
        end
    end

    // Response routing: last tag stage selects the owner of the adder result.
    always_comb begin
        rsp_valid = '0;
        rsp_data  = 8'h00;
        if (w_rsp) begin
            rsp_valid[r_tag_idx[ADD_LAT-1]] = 1'b1;
            rsp_data                        = add_c;
        end
    end

    // In-flight counter: +1 per issue, -1 per response, unchanged when both.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_inflight <= '0;
        end else begin
            case ({w_transfer, w_rsp})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign inflight_cnt = r_inflight;

endmodule

// File: tb/tb_fp8_add_arbiter.sv
// Bench for fp8_add_arbiter: N=4, ADD_LAT=4, with a 4-stage E4M3 adder model
// (positive normal operands, truncating) standing in for the external adder.
module tb_fp8_add_arbiter;

    localparam int N   = 4;
    localparam int LAT = 4;

    localparam logic [31:0] A_STD = 32'h48_30_40_38; // req3=4.0 req2=0.5 req1=2.0 req0=1.0
    localparam logic [31:0] A_T6  = 32'h48_40_40_38; // req2=2.0 for the burst test
    localparam logic [31:0] B_STD = 32'h38_38_38_38; // all b = 1.0

    logic         CLK;
    logic         RESETN;
    logic [3:0]   req_valid;
    logic [31:0]  req_a;
    logic [31:0]  req_b;
    logic [3:0]   req_ready;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic [7:0]   add_c;
    logic [3:0]   rsp_valid;
    logic [7:0]   rsp_data;
    logic [3:0]   inflight_cnt;

    int total = 0;
    int bad   = 0;

    fp8_add_arbiter #(.N(N), .ADD_LAT(LAT), .IDW(2)) dut (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .req_valid    (req_valid),
        .req_a        (req_a),
        .req_b        (req_b),
        .req_ready    (req_ready),
        .add_a        (add_a),
        .add_b        (add_b),
        .add_c        (add_c),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .inflight_cnt (inflight_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // E4M3 addition for positive normals (or zero), truncating the extra bit.
    function automatic logic [7:0] fp8_add(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] hi;
        logic [7:0] lo;
        logic [3:0] d;
        logic [4:0] s;
        if (x[6:0] >= y[6:0]) begin
            hi = x;
            lo = y;
        end else begin
            hi = y;
            lo = x;
        end
        if (lo[6:0] == 7'd0) return hi;
        d = hi[6:3] - lo[6:3];
        s = {2'b01, hi[2:0]} + ({2'b01, lo[2:0]} >> d);
        if (s[4]) return {1'b0, hi[6:3] + 4'd1, s[3:1]};
        return {1'b0, hi[6:3], s[2:0]};
    endfunction

    // Adder model: result appears LAT rising edges after the operands.
    logic [7:0] add_pipe [LAT];
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            for (int k = 0; k < LAT; k++) add_pipe[k] <= 8'h00;
        end else begin
            add_pipe[0] <= fp8_add(add_a, add_b);
            for (int k = 1; k < LAT; k++) add_pipe[k] <= add_pipe[k-1];
        end
    end
    assign add_c = add_pipe[LAT-1];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] a;
        logic [3:0]  ready;
        logic [7:0]  add_a;
        logic [3:0]  rsp;
        logic [7:0]  data;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic [3:0] v, input logic [31:0] a, input logic [3:0] rdy,
                       input logic [7:0] aa, input logic [3:0] rs, input logic [7:0] d,
                       input logic [3:0] c);
        vec_t e;
        e.valid = v; e.a = a; e.ready = rdy; e.add_a = aa;
        e.rsp = rs; e.data = d; e.cnt = c;
        tbl.push_back(e);
    endtask

    initial begin
        // ---- single op: req0 1.0+1.0 -> 2.0 (0x40), 4 edges later
        row(4'b0001, A_STD, 4'b0001, 8'h38, 4'b0000, 8'h00, 4'd0);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'd1);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'd1);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'd1);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0001, 8'h40, 4'd1);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'd0);
        // ---- only req1/req3 valid: alternate, wrapping past 3 back to 1
        row(4'b1010, A_STD, 4'b0010, 8'h40, 4'b0000, 8'h00, 4'd0);
        row(4'b1010, A_STD, 4'b1000, 8'h48, 4'b0000, 8'h00, 4'd1);
        row(4'b1010, A_STD, 4'b0010, 8'h40, 4'b0000, 8'h00, 4'd2);
        row(4'b1010, A_STD, 4'b1000, 8'h48, 4'b0000, 8'h00, 4'd3);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0010, 8'h44, 4'd4);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b1000, 8'h4A, 4'd3);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0010, 8'h44, 4'd2);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b1000, 8'h4A, 4'd1);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'd0);
        // ---- all four held valid: full throughput, count saturates at 4
        row(4'b1111, A_STD, 4'b0001, 8'h38, 4'b0000, 8'h00, 4'd0);
        row(4'b1111, A_STD, 4'b0010, 8'h40, 4'b0000, 8'h00, 4'd1);
        row(4'b1111, A_STD, 4'b0100, 8'h30, 4'b0000, 8'h00, 4'd2);
        row(4'b1111, A_STD, 4'b1000, 8'h48, 4'b0000, 8'h00, 4'd3);
        row(4'b1111, A_STD, 4'b0001, 8'h38, 4'b0001, 8'h40, 4'd4);
        row(4'b1111, A_STD, 4'b0010, 8'h40, 4'b0010, 8'h44, 4'd4);
        row(4'b1111, A_STD, 4'b0100, 8'h30, 4'b0100, 8'h3C, 4'd4);
        row(4'b1111, A_STD, 4'b1000, 8'h48, 4'b1000, 8'h4A, 4'd4);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0001, 8'h40, 4'd4);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0010, 8'h44, 4'd3);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0100, 8'h3C, 4'd2);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b1000, 8'h4A, 4'd1);
        row(4'b0000, A_STD, 4'b0000, 8'h00, 4'b0000, 8'h00, 4'd0);
        // ---- burst then idle: req2 2.0+1.0 -> 3.0 (0x44) three times
        row(4'b0100, A_T6,  4'b0100, 8'h40, 4'b0000, 8'h00, 4'd0);
        row(4'b0100, A_T6,  4'b0100, 8'h40, 4'b0000, 8'h00, 4'd1);
        row(4'b0100, A_T6,  4'b0100, 8'h40, 4'b0000, 8'h00, 4'd2);
        row(4'b0000, A_T6,  4'b0000, 8'h00, 4'b0000, 8'h00, 4'd3);
        row(4'b0000, A_T6,  4'b0000, 8'h00, 4'b0100, 8'h44, 4'd3);
        row(4'b0000, A_T6,  4'b0000, 8'h00, 4'b0100, 8'h44, 4'd2);
        row(4'b0000, A_T6,  4'b0000, 8'h00, 4'b0100, 8'h44, 4'd1);
        row(4'b0000, A_T6,  4'b0000, 8'h00, 4'b0000, 8'h00, 4'd0);

        // ---- reset with every requester asserting
        RESETN    = 1'b0;
        req_valid = 4'b1111;
        req_a     = A_STD;
        req_b     = B_STD;
        @(negedge CLK);
        @(negedge CLK);
        #1;
        check("rst_ready", 32'(req_ready),    32'h0);
        check("rst_rsp",   32'(rsp_valid),    32'h0);
        check("rst_add_a", 32'(add_a),        32'h0);
        check("rst_add_b", 32'(add_b),        32'h0);
        check("rst_cnt",   32'(inflight_cnt), 32'h0);
        req_valid = 4'b0000;
        @(negedge CLK);
        RESETN = 1'b1;

        // ---- table: one row per cycle, inputs at negedge, outputs 1ns later
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge CLK);
            req_valid = tbl[i].valid;
            req_a     = tbl[i].a;
            req_b     = B_STD;
            #1;
            check($sformatf("row%0d_ready", i), 32'(req_ready),    32'(tbl[i].ready));
            check($sformatf("row%0d_add_a", i), 32'(add_a),        32'(tbl[i].add_a));
            check($sformatf("row%0d_add_b", i), 32'(add_b),
                  (tbl[i].ready != 4'b0000) ? 32'h38 : 32'h00);
            check($sformatf("row%0d_rsp",   i), 32'(rsp_valid),    32'(tbl[i].rsp));
            check($sformatf("row%0d_data",  i), 32'(rsp_data),     32'(tbl[i].data));
            check($sformatf("row%0d_cnt",   i), 32'(inflight_cnt), 32'(tbl[i].cnt));
        end

        // ---- reset mid-flight: pointer is at 2, so req0..2 win in order 0,1,2
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            req_valid = 4'b0111;
            req_a     = A_STD;
            #1;
            check($sformatf("mid_issue%0d", i), 32'(req_ready), 32'(4'b0001 << i));
        end
        @(negedge CLK);
        req_valid = 4'b0000;
        RESETN    = 1'b0;
        #1;
        check("mid_rst_cnt",   32'(inflight_cnt), 32'h0);
        check("mid_rst_rsp",   32'(rsp_valid),    32'h0);
        check("mid_rst_ready", 32'(req_ready),    32'h0);
        @(negedge CLK);
        RESETN = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check($sformatf("mid_after%0d_rsp", i), 32'(rsp_valid),    32'h0);
            check($sformatf("mid_after%0d_cnt", i), 32'(inflight_cnt), 32'h0);
            @(negedge CLK);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
